// File: rtl/ram_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the RAM command port.
interface ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDR_SIZE-1:0] addr0;
  logic [ADDR_SIZE-1:0] addr1;
  logic [ADDR_SIZE-1:0] wdata0;
  logic [ADDR_SIZE-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 done0;
  logic                 done1;
  logic [ADDR_SIZE-1:0] rdata0;
  logic [ADDR_SIZE-1:0] rdata1;
  logic                 err0;
  logic                 err1;
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;
  logic                 busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ram_dout, ram_tx_valid,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    output ram_din, ram_rx_valid, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ram_dout, ram_tx_valid,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    input  ram_din, ram_rx_valid, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that lets two requesters share one serial RAM command port,
// issuing address and data command beats and collecting read data with a timeout.
module ram_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD_ADDR, CMD_DATA, WAIT_RD, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_owner;
  logic                 r_last;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_wdata;
  logic [ADDR_SIZE-1:0] r_rdata0;
  logic [ADDR_SIZE-1:0] r_rdata1;
  logic                 r_err0;
  logic                 r_err1;
  logic [CW-1:0]        r_cnt;

  logic                 w_any;
  logic                 w_winner;
  logic                 w_grant;
  logic                 w_rd_hit;
  logic                 w_timeout;
  logic                 w_wr_done;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_any     = bus.req0 | bus.req1;
    w_winner  = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    w_grant   = (r_state == IDLE) && w_any;
    w_rd_hit  = (r_state == WAIT_RD) && bus.ram_tx_valid;
    w_timeout = (r_state == WAIT_RD) && !bus.ram_tx_valid &&
                (r_cnt == CW'(RD_TIMEOUT - 1));
    w_wr_done = (r_state == CMD_DATA) && r_we;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_any) w_next = CMD_ADDR;
      CMD_ADDR: w_next = CMD_DATA;
      CMD_DATA: w_next = r_we ? DONE : WAIT_RD;
      WAIT_RD:  if (w_rd_hit || w_timeout) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // gnt is combinational in IDLE, so it is gated with rst_n to stay low in reset.
  always_comb begin
    bus.gnt0         = 1'b0;
    bus.gnt1         = 1'b0;
    bus.done0        = 1'b0;
    bus.done1        = 1'b0;
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    bus.busy         = (r_state != IDLE);
    if (w_grant && rst_n) begin
      bus.gnt0 = ~w_winner;
      bus.gnt1 = w_winner;
    end
    case (r_state)
      CMD_ADDR: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {(r_we ? 2'b00 : 2'b10), r_addr};
      end
      CMD_DATA: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = r_we ? {2'b01, r_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
      end
      DONE: begin
        bus.done0 = ~r_owner;
        bus.done1 = r_owner;
      end
      default: ;
    endcase
  end

  assign bus.rdata0 = r_rdata0;
  assign bus.rdata1 = r_rdata1;
  assign bus.err0   = r_err0;
  assign bus.err1   = r_err1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? bus.we1    : bus.we0;
        r_addr  <= w_winner ? bus.addr1  : bus.addr0;
        r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == CMD_DATA) r_cnt <= '0;
      else if (r_state == WAIT_RD) r_cnt <= r_cnt + CW'(1);
      // Result flags are updated on entry to DONE so they are valid with done.
      if (w_rd_hit) begin
        if (r_owner) begin
          r_rdata1 <= bus.ram_dout;
          r_err1   <= 1'b0;
        end else begin
          r_rdata0 <= bus.ram_dout;
          r_err0   <= 1'b0;
        end
      end
      if (w_timeout) begin
        if (r_owner) r_err1 <= 1'b1;
        else         r_err0 <= 1'b1;
      end
      if (w_wr_done) begin
        if (r_owner) r_err1 <= 1'b0;
        else         r_err0 <= 1'b0;
      end
      if (r_state == DONE) r_last <= r_owner;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand-written reset/drop sequences and
// randomized rounds checked against a transaction-level model with a RAM array.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int T  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_SIZE(AW)) bus();
  ram_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] mem [256];
  logic [AW-1:0] mRdata [2];
  logic          mErr [2];
  int            mLast;

  typedef struct {
    logic [1:0]    mask;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [AW-1:0] wdata0;
    int            dly0;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [AW-1:0] wdata1;
    int            dly1;
    int            expFirst;
    logic [AW-1:0] expRd0;
    logic          expErr0;
    logic [AW-1:0] expRd1;
    logic          expErr1;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [AW-1:0] wdata);
    if (who == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  function automatic logic gntOf(input int w);
    return (w == 1) ? bus.gnt1 : bus.gnt0;
  endfunction
  function automatic logic doneOf(input int w);
    return (w == 1) ? bus.done1 : bus.done0;
  endfunction
  function automatic logic [AW-1:0] rdOf(input int w);
    return (w == 1) ? bus.rdata1 : bus.rdata0;
  endfunction
  function automatic logic errOf(input int w);
    return (w == 1) ? bus.err1 : bus.err0;
  endfunction

  // Called just after the rising edge of the cycle in which the grant is expected;
  // returns just after the rising edge of the IDLE cycle following done.
  task automatic serveOne(input int who, input logic we, input logic [AW-1:0] addr,
                          input logic [AW-1:0] wdata, input int delay);
    int other;
    int expK;
    logic early;
    logic [AW+1:0] expDin;
    other = 1 - who;
    early = 1'b0;
    @(negedge clk);
    checkOutput("gnt_owner", 32'(gntOf(who)), 32'd1);
    checkOutput("gnt_other", 32'(gntOf(other)), 32'd0);
    checkOutput("busy_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    applyStimulus(who, 1'b0, we, addr, wdata);
    @(negedge clk);
    expDin = {(we ? 2'b00 : 2'b10), addr};
    checkOutput("din_addr", 32'(bus.ram_din), 32'(expDin));
    checkOutput("rx_addr", 32'(bus.ram_rx_valid), 32'd1);
    checkOutput("busy_cmd", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    expDin = we ? {2'b01, wdata} : {2'b11, {AW{1'b0}}};
    checkOutput("din_data", 32'(bus.ram_din), 32'(expDin));
    checkOutput("rx_data", 32'(bus.ram_rx_valid), 32'd1);
    if (we) expK = 1;
    else    expK = (delay <= T) ? delay + 1 : T + 1;
    for (int k = 1; k <= expK; k++) begin
      @(posedge clk); #1;
      if (!we && k == delay) begin
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = mem[addr];
      end else begin
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = AW'($urandom);
      end
      @(negedge clk);
      if (k < expK && (bus.done0 || bus.done1 || bus.ram_rx_valid || !bus.busy)) early = 1'b1;
    end
    checkOutput("no_early_done", 32'(early), 32'd0);
    if (we) begin
      mem[addr] = wdata;
      mErr[who] = 1'b0;
    end else if (delay <= T) begin
      mRdata[who] = mem[addr];
      mErr[who]   = 1'b0;
    end else begin
      mErr[who] = 1'b1;
    end
    mLast = who;
    checkOutput("done_owner", 32'(doneOf(who)), 32'd1);
    checkOutput("done_other", 32'(doneOf(other)), 32'd0);
    checkOutput("rdata_owner", 32'(rdOf(who)), 32'(mRdata[who]));
    checkOutput("err_owner", 32'(errOf(who)), 32'(mErr[who]));
    checkOutput("rdata_other", 32'(rdOf(other)), 32'(mRdata[other]));
    checkOutput("err_other", 32'(errOf(other)), 32'(mErr[other]));
    @(posedge clk); #1;
    bus.ram_tx_valid = 1'b0;
  endtask

  task automatic runRound(input logic [1:0] mask, input int first,
                          input logic we0, input logic [AW-1:0] a0, input logic [AW-1:0] d0, input int l0,
                          input logic we1, input logic [AW-1:0] a1, input logic [AW-1:0] d1, input int l1);
    if (mask[0]) applyStimulus(0, 1'b1, we0, a0, d0);
    if (mask[1]) applyStimulus(1, 1'b1, we1, a1, d1);
    if (first == 0) begin
      serveOne(0, we0, a0, d0, l0);
      if (mask[1]) serveOne(1, we1, a1, d1, l1);
    end else begin
      serveOne(1, we1, a1, d1, l1);
      if (mask[0]) serveOne(0, we0, a0, d0, l0);
    end
  endtask

  task automatic resetModel();
    mRdata[0] = '0; mRdata[1] = '0;
    mErr[0]   = 1'b0; mErr[1] = 1'b0;
    mLast     = 1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic flag;
    logic [1:0] mask;
    int first;
    logic rwe [2];
    logic [AW-1:0] ra [2];
    logic [AW-1:0] rd [2];
    int rl [2];

    for (int i = 0; i < 256; i++) mem[i] = '0;
    resetModel();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    bus.ram_tx_valid = 1'b0;
    bus.ram_dout     = '0;

    vecs[0] = '{2'b01, 1'b1, 8'h12, 8'hA5, 1, 1'b0, 8'h00, 8'h00, 1, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{2'b10, 1'b0, 8'h00, 8'h00, 1, 1'b0, 8'h12, 8'h00, 1, 1, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{2'b11, 1'b1, 8'h34, 8'h5A, 1, 1'b1, 8'h56, 8'hC3, 1, 0, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 8'h34, 8'h00, 2, 1'b0, 8'h56, 8'h00, 1, 0, 8'h5A, 1'b0, 8'hC3, 1'b0};
    vecs[4] = '{2'b01, 1'b0, 8'h77, 8'h00, 9, 1'b0, 8'h00, 8'h00, 1, 0, 8'h5A, 1'b1, 8'hC3, 1'b0};
    vecs[5] = '{2'b11, 1'b1, 8'h77, 8'h11, 1, 1'b0, 8'h77, 8'h00, 1, 1, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{2'b11, 1'b0, 8'h77, 8'h00, 4, 1'b0, 8'h12, 8'h00, 5, 1, 8'h11, 1'b0, 8'h00, 1'b1};

    applyStimulus(0, 1'b1, 1'b1, 8'h12, 8'hA5);
    @(negedge clk);
    checkOutput("rst_gnt0", 32'(bus.gnt0), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_rx", 32'(bus.ram_rx_valid), 32'd0);
    checkOutput("rst_din", 32'(bus.ram_din), 32'd0);
    checkOutput("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    checkOutput("rst_rdata", 32'({bus.rdata0, bus.rdata1}), 32'd0);
    checkOutput("rst_err", 32'({bus.err0, bus.err1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int v = 0; v < 7; v++) begin
      runRound(vecs[v].mask, vecs[v].expFirst,
               vecs[v].we0, vecs[v].addr0, vecs[v].wdata0, vecs[v].dly0,
               vecs[v].we1, vecs[v].addr1, vecs[v].wdata1, vecs[v].dly1);
      checkOutput($sformatf("vec%0d_rdata0", v), 32'(bus.rdata0), 32'(vecs[v].expRd0));
      checkOutput($sformatf("vec%0d_err0", v), 32'(bus.err0), 32'(vecs[v].expErr0));
      checkOutput($sformatf("vec%0d_rdata1", v), 32'(bus.rdata1), 32'(vecs[v].expRd1));
      checkOutput($sformatf("vec%0d_err1", v), 32'(bus.err1), 32'(vecs[v].expErr1));
    end

    $display("[TB] request dropped before grant");
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 8'h99);
    fork
      serveOne(0, 1'b1, 8'h20, 8'h99, 1);
      begin
        repeat (2) @(posedge clk);
        #2 applyStimulus(1, 1'b1, 1'b0, 8'h55, 8'h00);
        @(posedge clk);
        #2 applyStimulus(1, 1'b0, 1'b0, 8'h55, 8'h00);
      end
    join
    @(negedge clk);
    checkOutput("drop_gnt1", 32'(bus.gnt1), 32'd0);
    checkOutput("drop_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("drop_busy_later", 32'(bus.busy), 32'd0);
    checkOutput("drop_rdata1", 32'(bus.rdata1), 32'(mRdata[1]));
    checkOutput("drop_err1", 32'(bus.err1), 32'(mErr[1]));
    @(posedge clk); #1;

    $display("[TB] reset during CMD_DATA");
    applyStimulus(1, 1'b1, 1'b1, 8'h40, 8'h66);
    @(negedge clk);
    checkOutput("mid_gnt1", 32'(bus.gnt1), 32'd1);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b1, 8'h40, 8'h66);
    @(posedge clk); #3;
    checkOutput("mid_rx_before", 32'(bus.ram_rx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rx", 32'(bus.ram_rx_valid), 32'd0);
    checkOutput("mid_din", 32'(bus.ram_din), 32'd0);
    checkOutput("mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_err", 32'({bus.err0, bus.err1}), 32'd0);
    checkOutput("mid_rdata", 32'({bus.rdata0, bus.rdata1}), 32'd0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) flag = 1'b1;
    end
    checkOutput("mid_no_done", 32'(flag), 32'd0);
    rst_n = 1'b1;
    resetModel();
    @(posedge clk); #1;
    runRound(2'b11, 0, 1'b0, 8'h40, 8'h00, 1, 1'b1, 8'h40, 8'h66, 1);
    applyStimulus(0, 1'b1, 1'b0, 8'h40, 8'h00);
    serveOne(0, 1'b0, 8'h40, 8'h00, 1);
    checkOutput("post_rst_read", 32'(bus.rdata0), 32'h66);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 30; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int w = 0; w < 2; w++) begin
        rwe[w] = 1'($urandom_range(0, 1));
        ra[w]  = AW'($urandom_range(0, 7));
        rd[w]  = AW'($urandom);
        rl[w]  = $urandom_range(1, T + 2);
      end
      if (mask == 2'b11) first = (mLast == 1) ? 0 : 1;
      else               first = (mask == 2'b10) ? 1 : 0;
      runRound(mask, first, rwe[0], ra[0], rd[0], rl[0], rwe[1], ra[1], rd[1], rl[1]);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
